dat_timeout_multi: RTL
======================

DAT_TIMEOUT_MULTI -- requirements
Module: dat_timeout_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timeout channels (e.g. read, write-busy).
REQ-002 SHALL have parameter CNT_WIDTH, default 28, per-channel counter width; legal values are >= 28.
REQ-003 SHALL have parameter PRESCALE, default 1, clk_i cycles per count tick; legal values are >= 1.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port running_i, input, NUM_CH, per-channel transfer-in-progress level.
REQ-007 SHALL have port pause_i, input, NUM_CH, per-channel freeze level (card clock stopped, block gap).
REQ-008 SHALL have port restart_i, input, NUM_CH, per-channel one-cycle pulse that zeroes the count (block boundary).
REQ-009 SHALL have port clear_i, input, NUM_CH, per-channel one-cycle pulse that acknowledges an expiry.
REQ-010 SHALL have port timeout_bits_i, input, 4, shared data-timeout exponent.
REQ-011 SHALL have port irq_en_i, input, NUM_CH, per-channel interrupt enable.
REQ-012 SHALL have port busy_o, output, NUM_CH, high while the channel is in COUNT or PAUSED.
REQ-013 SHALL have port timeout_o, output, NUM_CH, sticky expiry flag, high in EXPIRED.
REQ-014 SHALL have port expired_o, output, NUM_CH, one-cycle pulse on entry to EXPIRED.
REQ-015 SHALL have port irq_o, output, 1, equal to OR over channels of (timeout_o AND irq_en_i).

Function
REQ-016 SHALL generate one shared tick: a free-running prescaler asserts tick in one of every PRESCALE cycles; with PRESCALE=1, tick is constantly high.
REQ-017 SHALL compute threshold = 2^(min(timeout_bits_i,14)+13), so codes 14 and 15 both give 2^27, from the live input each cycle.
REQ-018 SHALL give each channel states IDLE, COUNT, PAUSED and EXPIRED, with its own CNT_WIDTH counter.
REQ-019 SHALL in IDLE hold count 0 and move to COUNT (or to PAUSED if pause_i is high) when running_i is high.
REQ-020 SHALL in COUNT increment count by 1 on each tick and move to PAUSED when pause_i is high.
REQ-021 SHALL in PAUSED hold count and return to COUNT when pause_i falls.
REQ-022 SHALL in COUNT move to EXPIRED when count >= threshold, holding count; this compare takes priority over pause_i in the same cycle.
REQ-023 SHALL in COUNT or PAUSED go to IDLE with count 0 when running_i is low; this takes priority over every other event.
REQ-024 SHALL in COUNT or PAUSED zero the count when restart_i is high; restart wins over a same-cycle increment, and pause_i still selects the next state.
REQ-025 SHALL in EXPIRED ignore running_i, pause_i and restart_i, and leave only on clear_i, to IDLE with count 0; the channel re-arms on the next cycle if running_i is still high.
REQ-026 SHALL ignore clear_i in any state other than EXPIRED.
REQ-027 SHALL apply a threshold lowered mid-run below the current count on the next cycle, expiring then.
REQ-028 SHALL keep channels fully independent except for the shared tick, threshold and irq_o.
REQ-029 SHALL drive all outputs from registered state, with no combinational path from inputs except the irq_en_i term into irq_o.

Reset
REQ-030 SHALL on rst_i force all channels to IDLE, counts and prescaler to 0, and busy_o, timeout_o, expired_o and irq_o to 0.
REQ-031 SHALL on rst_i asserted mid-transfer abort immediately, with no expired_o pulse.

Verification
REQ-032 SHALL cover this case: PRESCALE=1, bits=0, running_i[0] rises before edge 1 and stays high -> busy_o[0] is high after edge 1, and timeout_o[0] and expired_o[0] are high after edge 8194, with expired_o[0] low after edge 8195.
REQ-033 SHALL cover this case: same setup with pause_i[0] high for 100 cycles mid-count -> expiry is delayed by exactly 100 cycles.
REQ-034 SHALL cover this case: restart_i[0] pulsed at count 8000 -> expiry occurs 8193 cycles after the pulse.
REQ-035 SHALL cover this case: channel 0 expired and irq_en_i=01, then clear_i[0] pulsed with running_i low -> irq_o goes 1 then 0, and the channel returns to IDLE with busy_o[0]=0.
REQ-036 SHALL cover this case: bits=15 with PRESCALE=4 -> expiry occurs between 4*2^27 and 4*2^27+4 cycles after start (short-CNT check via forced count).
REQ-037 SHALL cover this case: both channels running, with running_i[1] dropping at count 5000 -> channel 1 goes to IDLE while channel 0 expires on schedule.

Source files
------------

// File: rtl/dat_timeout_multi.sv
// dat_timeout_multi: independent data-timeout timers, one per channel, that share
// a prescaled count tick and a power-of-two expiry threshold.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no transfer; count held at 0, waiting for running_i
// S_COUNT   | transfer active; count advances on each shared tick
// S_PAUSED  | transfer active but frozen (card clock stopped / block gap)
// S_EXPIRED | threshold reached; sticky until acknowledged by clear_i
module dat_timeout_multi #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 28,
    parameter int PRESCALE  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] running_i,
    input  logic [NUM_CH-1:0] pause_i,
    input  logic [NUM_CH-1:0] restart_i,
    input  logic [NUM_CH-1:0] clear_i,
    input  logic [3:0]        timeout_bits_i,
    input  logic [NUM_CH-1:0] irq_en_i,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] timeout_o,
    output logic [NUM_CH-1:0] expired_o,
    output logic              irq_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_e;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]                     presc_q, presc_d;
    logic                              tick;
    logic [3:0]                        exp_sel;
    logic [4:0]                        shamt;
    logic [CNT_WIDTH-1:0]              thresh;
    state_e                            state_q [NUM_CH];
    state_e                            state_d [NUM_CH];
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0]                 expired_q, expired_d;

    // Shared tick: one cycle in every PRESCALE; permanently high when PRESCALE is 1.
    always_comb begin
        tick    = 1'b1;
        presc_d = '0;
        if (PRESCALE > 1) begin
            tick    = (presc_q == PW'(PRESCALE - 1));
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Threshold 2^(min(bits,14)+13), taken from the live exponent every cycle.
    always_comb begin
        exp_sel = (timeout_bits_i > 4'd14) ? 4'd14 : timeout_bits_i;
        shamt   = {1'b0, exp_sel} + 5'd13;
        thresh  = {{(CNT_WIDTH-1){1'b0}}, 1'b1} << shamt;
    end

    // Per-channel next state and count; dropping running_i beats everything,
    // the expiry compare beats pause, and restart beats a same-cycle increment.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]   = state_q[c];
            cnt_d[c]     = cnt_q[c];
            expired_d[c] = 1'b0;
            case (state_q[c])
                S_IDLE: begin
                    cnt_d[c] = '0;
                    if (running_i[c]) begin
                        state_d[c] = pause_i[c] ? S_PAUSED : S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (!running_i[c]) begin
                        state_d[c] = S_IDLE;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] >= thresh) begin
                        state_d[c]   = S_EXPIRED;
                        expired_d[c] = 1'b1;
                    end else begin
                        if (restart_i[c]) begin
                            cnt_d[c] = '0;
                        end else if (tick) begin
                            cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
                        end
                        state_d[c] = pause_i[c] ? S_PAUSED : S_COUNT;
                    end
                end
                S_PAUSED: begin
                    if (!running_i[c]) begin
                        state_d[c] = S_IDLE;
                        cnt_d[c]   = '0;
                    end else begin
                        if (restart_i[c]) begin
                            cnt_d[c] = '0;
                        end
                        state_d[c] = pause_i[c] ? S_PAUSED : S_COUNT;
                    end
                end
                S_EXPIRED: begin
                    if (clear_i[c]) begin
                        state_d[c] = S_IDLE;
                        cnt_d[c]   = '0;
                    end
                end
                default: begin
                    state_d[c] = S_IDLE;
                    cnt_d[c]   = '0;
                end
            endcase
        end
    end

    // State, count, prescaler and expiry-pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            expired_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= S_IDLE;
            end
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
            end
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy_o    = '0;
        timeout_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            busy_o[c]    = (state_q[c] == S_COUNT) || (state_q[c] == S_PAUSED);
            timeout_o[c] = (state_q[c] == S_EXPIRED);
        end
    end

    assign expired_o = expired_q;
    assign irq_o     = |(timeout_o & irq_en_i);

endmodule
